// File: rtl/alu_arbiter_pkg.sv
// RV32I ALU op encodings shared by the arbiter and its ALU core.
// Compute ops use {funct7[5], funct3}; branch ops use {2'b11, funct3}.
package ALUOps;

  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_BEQ  = 5'b11000,
    ALU_BNE  = 5'b11001,
    ALU_BLT  = 5'b11100,
    ALU_BGE  = 5'b11101,
    ALU_BLTU = 5'b11110,
    ALU_BGEU = 5'b11111
  } alu_op_e;

  function automatic logic alu_op_is_legal(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
      ALU_SUB, ALU_SRA, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic alu_op_is_branch(input logic [ALU_OP_W-1:0] op);
    return op[ALU_OP_W-1];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational RV32I ALU: compute result, branch-compare flag and
// illegal-op indication.
module alu_core
  import ALUOps::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [XLEN-1:0]     result_o,
  output logic                flag_o,
  output logic                err_o
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;
  logic       eq;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    err_o    = 1'b0;
    if (!alu_op_is_legal(alu_op_i)) begin
      err_o = 1'b1;
    end else if (alu_op_is_branch(alu_op_i)) begin
      case (alu_op_i)
        ALU_BEQ:  flag_o = eq;
        ALU_BNE:  flag_o = !eq;
        ALU_BLT:  flag_o = lt_s;
        ALU_BGE:  flag_o = !lt_s;
        ALU_BLTU: flag_o = lt_u;
        ALU_BGEU: flag_o = !lt_u;
        default:  flag_o = 1'b0;
      endcase
    end else begin
      case (alu_op_i)
        ALU_ADD:  result_o = a_i + b_i;
        ALU_SUB:  result_o = a_i - b_i;
        ALU_SLL:  result_o = a_i << shamt;
        ALU_SRL:  result_o = a_i >> shamt;
        ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
        ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
        ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
        ALU_XOR:  result_o = a_i ^ b_i;
        ALU_OR:   result_o = a_i | b_i;
        ALU_AND:  result_o = a_i & b_i;
        default:  result_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters; one
// transaction in flight, registered response held until accepted.
module alu_arbiter
  import ALUOps::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_op_i,
  input  logic [NUM_REQ*XLEN-1:0]      req_a_i,
  input  logic [NUM_REQ*XLEN-1:0]      req_b_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [XLEN-1:0]              rsp_result_o,
  output logic                         rsp_flag_o,
  output logic                         rsp_err_o
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        gnt_q, gnt_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  flag_q, flag_d;
  logic                  err_q, err_d;

  logic [2*NUM_REQ-1:0]  valid_dbl;
  logic [NUM_REQ-1:0]    valid_rot;
  logic                  gnt_found;
  logic [IDW-1:0]        gnt_id;
  int                    gnt_idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [NUM_REQ-1:0]    gnt_oh_q;

  logic [ALU_OP_W-1:0]   op_sel;
  logic [XLEN-1:0]       a_sel;
  logic [XLEN-1:0]       b_sel;

  logic [XLEN-1:0]       alu_result;
  logic                  alu_flag;
  logic                  alu_err;

  // Rotate valids so bit 0 is the requester just after rr_ptr; the first set
  // bit then maps back to an absolute id with a single wrap subtraction.
  always_comb begin
    valid_dbl = {req_valid_i, req_valid_i};
    valid_rot = valid_dbl[int'(rr_ptr_q) + 1 +: NUM_REQ];
    gnt_found = 1'b0;
    gnt_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && valid_rot[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = int'(rr_ptr_q) + 1 + int'(i);
      end
    end
    if (gnt_idx >= int'(NUM_REQ)) begin
      gnt_idx = gnt_idx - int'(NUM_REQ);
    end
    gnt_id = IDW'(gnt_idx);
    gnt_oh = gnt_found ? (NUM_REQ'(1) << gnt_id) : '0;
  end

  assign gnt_oh_q = NUM_REQ'(1) << gnt_q;

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        op_sel = req_op_i[i*ALU_OP_W +: ALU_OP_W];
        a_sel  = req_a_i[i*XLEN +: XLEN];
        b_sel  = req_b_i[i*XLEN +: XLEN];
      end
    end
  end

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .alu_op_i (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_result),
    .flag_o   (alu_flag),
    .err_o    (alu_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      gnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d  = EXEC;
          rr_ptr_d = gnt_id;
          gnt_d    = gnt_id;
          op_d     = op_sel;
          a_d      = a_sel;
          b_d      = b_sel;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flag_d   = alu_flag;
        err_d    = alu_err;
        state_d  = RESP;
      end
      RESP: begin
        if (|(rsp_ready_i & gnt_oh_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE) ? gnt_oh : '0;
    rsp_valid_o  = (state_q == RESP) ? gnt_oh_q : '0;
    rsp_result_o = result_q;
    rsp_flag_o   = flag_q;
    rsp_err_o    = err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single ops plus hand-written
// sequences for round-robin, backpressure and reset corner cases.
module tb_alu_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned XLEN    = 32;

  logic                  clk_i;
  logic                  rst_ni;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*5-1:0]  req_op_i;
  logic [NUM_REQ*XLEN-1:0] req_a_i;
  logic [NUM_REQ*XLEN-1:0] req_b_i;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [NUM_REQ-1:0]    rsp_ready_i;
  logic [XLEN-1:0]       rsp_result_o;
  logic                  rsp_flag_o;
  logic                  rsp_err_o;

  int checks;
  int errors;

  alu_arbiter #(
    .NUM_REQ (NUM_REQ),
    .XLEN    (XLEN)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_flag_o   (rsp_flag_o),
    .rsp_err_o    (rsp_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          r;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        flag;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input int r, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    req_valid_i = 2'(1 << r);
    req_op_i[5*r +: 5]     = op;
    req_a_i[32*r +: 32]    = a;
    req_b_i[32*r +: 32]    = b;
  endtask

  // Full transaction on one requester with exact-latency checks.
  task automatic run_op(input string nm, input vec_t v);
    logic [1:0] oh;
    oh = 2'(1 << v.r);
    @(negedge clk_i);
    drive_req(v.r, v.op, v.a, v.b);
    #1 chk({nm, " ready"}, 32'(req_ready_o), 32'(oh));
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    chk({nm, " exec_novalid"}, 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i);
    chk({nm, " rsp_valid"}, 32'(rsp_valid_o), 32'(oh));
    chk({nm, " result"}, rsp_result_o, v.res);
    chk({nm, " flag"}, 32'(rsp_flag_o), 32'(v.flag));
    chk({nm, " err"}, 32'(rsp_err_o), 32'(v.err));
    rsp_ready_i = oh;
    @(negedge clk_i);
    rsp_ready_i = '0;
    chk({nm, " rsp_done"}, 32'(rsp_valid_o), 32'd0);
    chk({nm, " result_kept"}, rsp_result_o, v.res);
  endtask

  initial begin
    logic [1:0]  seen_oh[4];
    logic [31:0] seen_res[4];
    int          got;
    int          seen;

    checks = 0;
    errors = 0;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = '0;

    vecs[0]  = '{r: 0, op: 5'b00000, a: 32'd5,        b: 32'd7,        res: 32'd12,       flag: 0, err: 0};
    vecs[1]  = '{r: 1, op: 5'b01000, a: 32'd5,        b: 32'd7,        res: 32'hFFFFFFFE, flag: 0, err: 0};
    vecs[2]  = '{r: 0, op: 5'b11100, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0,        flag: 1, err: 0};
    vecs[3]  = '{r: 1, op: 5'b11110, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0,        flag: 0, err: 0};
    vecs[4]  = '{r: 0, op: 5'b00010, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd1,        flag: 0, err: 0};
    vecs[5]  = '{r: 1, op: 5'b00011, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0,        flag: 0, err: 0};
    vecs[6]  = '{r: 0, op: 5'b01101, a: 32'h80000000, b: 32'd4,        res: 32'hF8000000, flag: 0, err: 0};
    vecs[7]  = '{r: 1, op: 5'b00001, a: 32'd1,        b: 32'd33,       res: 32'd2,        flag: 0, err: 0};
    vecs[8]  = '{r: 0, op: 5'b00101, a: 32'h80000000, b: 32'd31,       res: 32'd1,        flag: 0, err: 0};
    vecs[9]  = '{r: 1, op: 5'b00100, a: 32'h0000F0F0, b: 32'h0000FF00, res: 32'h00000FF0, flag: 0, err: 0};
    vecs[10] = '{r: 0, op: 5'b00110, a: 32'h00000F0F, b: 32'h0000F000, res: 32'h0000FF0F, flag: 0, err: 0};
    vecs[11] = '{r: 1, op: 5'b00111, a: 32'h0000F0F0, b: 32'h0000FF00, res: 32'h0000F000, flag: 0, err: 0};
    vecs[12] = '{r: 0, op: 5'b11000, a: 32'd3,        b: 32'd3,        res: 32'd0,        flag: 1, err: 0};
    vecs[13] = '{r: 1, op: 5'b11001, a: 32'd3,        b: 32'd3,        res: 32'd0,        flag: 0, err: 0};
    vecs[14] = '{r: 0, op: 5'b11101, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0,        flag: 0, err: 0};
    vecs[15] = '{r: 1, op: 5'b10000, a: 32'd9,        b: 32'd9,        res: 32'd0,        flag: 0, err: 1};
    vecs[16] = '{r: 0, op: 5'b01001, a: 32'd9,        b: 32'd9,        res: 32'd0,        flag: 0, err: 1};

    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_reset ready", 32'(req_ready_o), 32'd0);
    chk("post_reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("post_reset result", rsp_result_o, 32'd0);

    foreach (vecs[k]) begin
      run_op($sformatf("vec%0d", k), vecs[k]);
    end

    // Mid-simulation reset with no requests pending.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midreset rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("midreset result", rsp_result_o, 32'd0);
    chk("midreset flag", 32'(rsp_flag_o), 32'd0);
    chk("midreset err", 32'(rsp_err_o), 32'd0);
    chk("midreset ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_valid_i = 2'b01;
    #1 chk("release ready comb", 32'(req_ready_o), 32'd1);
    req_valid_i = '0;

    // Both requesters continuously valid: expect strict alternation 0,1,0,1.
    @(negedge clk_i);
    drive_req(0, 5'b00000, 32'd1, 32'd1);
    req_valid_i = 2'b11;
    req_op_i[9:5] = 5'b00000;
    req_a_i[63:32] = 32'd2;
    req_b_i[63:32] = 32'd2;
    rsp_ready_i = 2'b11;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o != '0) begin
        seen_oh[got]  = rsp_valid_o;
        seen_res[got] = rsp_result_o;
        got++;
      end
    end
    req_valid_i = '0;
    chk("rr count", 32'(got), 32'd4);
    for (int k = 0; k < got; k++) begin
      chk($sformatf("rr%0d grant", k), 32'(seen_oh[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d result", k), seen_res[k], (k % 2 == 0) ? 32'd2 : 32'd4);
    end
    repeat (4) @(negedge clk_i);
    rsp_ready_i = '0;

    // Backpressure on requester 0 while requester 1 waits and pokes its ready.
    @(negedge clk_i);
    drive_req(0, 5'b00000, 32'd10, 32'd20);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    req_valid_i = 2'b10;
    rsp_ready_i = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid_o), 32'd1);
      chk($sformatf("bp%0d result", c), rsp_result_o, 32'd30);
      chk($sformatf("bp%0d ready", c), 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    chk("bp release rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp release ready", 32'(req_ready_o), 32'd2);
    req_valid_i = '0;
    rsp_ready_i = '0;

    // Reset during EXEC: the in-flight request must never respond.
    @(negedge clk_i);
    drive_req(0, 5'b00000, 32'd3, 32'd4);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = '0;
    rsp_ready_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    chk("exec_reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("exec_reset result", rsp_result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o != '0) seen = 1;
    end
    chk("exec_reset no_rsp", 32'(seen), 32'd0);
    rsp_ready_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
